sync_generator: RTL and testbench
=================================

# sync_generator

Programmable raster timing generator for the HDMI output path in the `pxlClk` domain. It produces `hsync`, `vsync` and `de` with a configurable sync polarity, so the sync pulses can be driven at either level. It also outputs the current pixel coordinates and a per-frame start pulse for the overlay/pixel pipeline. It is the transmit-side counterpart to input sync normalisation: the overlay logic works internally with active-high syncs, and this block regenerates outgoing timing at the polarity the sink expects.

## Interface
- `H_ACTIVE`, default 1280: visible pixels per line
- `H_FP`, default 110: horizontal front porch, in pixels
- `H_SYNC`, default 40: hsync pulse width, in pixels
- `H_BP`, default 220: horizontal back porch, in pixels
- `V_ACTIVE`, default 720: visible lines per frame
- `V_FP`, default 5: vertical front porch, in lines
- `V_SYNC`, default 5: vsync pulse width, in lines
- `V_BP`, default 20: vertical back porch, in lines
- `HSYNC_POL`, default 1: asserted level of `hsync_o` (1 = active-high, 0 = active-low)
- `VSYNC_POL`, default 1: asserted level of `vsync_o`
- `pxlClk`  in  1  pixel clock, ≤165 MHz
- `rst`  in  1  asynchronous, active-low reset
- `en`  in  1  run enable, synchronous
- `hsync_o`  out  1  horizontal sync, at `HSYNC_POL`
- `vsync_o`  out  1  vertical sync, at `VSYNC_POL`
- `de_o`  out  1  active-video strobe, active-high
- `x_o`  out  12  horizontal counter value
- `y_o`  out  12  vertical counter value
- `frame_start_o`  out  1  one-cycle pulse at pixel (0,0)

## Operation
- Internal counters:
  - `hcnt` runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - `vcnt` runs 0..V_TOTAL-1, defined the same way from the V_ parameters.
  - Both are 12-bit. Parameters must satisfy H_TOTAL ≤ 4096 and V_TOTAL ≤ 4096.
- Each line is ordered active → front porch → sync → back porch. Frames use the same order, in lines.
- Counter advance when `en`=1:
  - `hcnt` increments every cycle.
  - At `hcnt` = H_TOTAL-1, `hcnt` wraps to 0 and `vcnt` increments.
  - At `hcnt` = H_TOTAL-1 and `vcnt` = V_TOTAL-1, both wrap to 0.
- Decode, evaluated from the current counters:
  - de = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE)
  - hs = H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC
  - vs = V_ACTIVE+V_FP ≤ vcnt < V_ACTIVE+V_FP+V_SYNC
  - vs changes only when `hcnt` wraps, so vsync edges are aligned to the start of a line (hcnt = 0).
  - fs = (hcnt == 0) && (vcnt == 0)
- Output polarity:
  - `hsync_o` = hs ? HSYNC_POL : ~HSYNC_POL
  - `vsync_o` = vs ? VSYNC_POL : ~VSYNC_POL
- `en`=0 idle behaviour:
  - Counters are forced to 0 on the next edge.
  - All outputs go to the idle state (same as the reset state) on the next edge.
  - On re-enable, timing restarts from (0,0) with a `frame_start_o` pulse; no partial line or frame is emitted.
- `en` dropping mid-frame truncates the frame immediately.
- Asserting reset mid-frame:
  - All state and outputs go to the reset state asynchronously.
  - After release, behaviour is identical to the first start.

## Timing
- All outputs are registered. Outputs at edge n reflect the counter state held before edge n, i.e. 1 cycle of latency from counter to pins.
- `x_o`/`y_o` are registered in the same stage as `de_o`, so coordinate and strobe are always aligned.
- Reset state, applied during `rst`=0 and held while `en`=0:
  - `hcnt` = `vcnt` = 0
  - `hsync_o` = ~HSYNC_POL, `vsync_o` = ~VSYNC_POL
  - `de_o` = 0, `frame_start_o` = 0
  - `x_o` = `y_o` = 0
- Start-up after the first edge with `rst`=1 and `en`=1:
  - The first registered output is `de_o`=1, `frame_start_o`=1, `x_o`=0, `y_o`=0.
  - `frame_start_o` then stays 0 for exactly H_TOTAL·V_TOTAL−1 cycles before the next pulse.
- `de_o` high time per line is exactly H_ACTIVE cycles. Active lines per frame are exactly V_ACTIVE.
- hsync assertion: `hsync_o` asserts H_ACTIVE+H_FP cycles after the `de_o` rising edge of the same line and stays asserted for H_SYNC cycles.
- vsync assertion:
  - `vsync_o` asserts in the same cycle `x_o`=0 presents `y_o` = V_ACTIVE+V_FP.
  - It stays asserted for V_SYNC·H_TOTAL cycles.
- Degenerate porches: H_FP=0 or H_BP=0 is legal, with sync immediately adjacent to active video or to the line wrap. H_SYNC and V_SYNC must be ≥1.

## Test plan
- Reset: hold `rst`=0 with `en`=1 → `hsync_o`=0, `vsync_o`=0, `de_o`=0, `frame_start_o`=0, `x_o`/`y_o`=0 with default polarity. Release `rst` → the first output cycle shows `de_o`=1, `frame_start_o`=1.
- Small raster (H 8/2/2/2, V 4/1/1/1, H_TOTAL=14, V_TOTAL=7) → `de_o` high for 8 cycles per line on lines 0–3. `hsync_o` high at x=10..11. `vsync_o` high for the whole of line 5 (14 cycles). `frame_start_o` period = 98 cycles.
- Polarity: same raster with HSYNC_POL=0 and VSYNC_POL=0 → `hsync_o` idle at 1, low at x=10..11. `vsync_o` idle at 1, low only during line 5. `de_o` is unchanged.
- Enable drop: deassert `en` at x=5, y=2 → next cycle all outputs idle and counters 0. Reassert after 20 cycles → the next output is `frame_start_o`=1 at (0,0).
- Default 720p: run 2 frames → 1650 cycles per line, 750 lines per frame, 921600 `de_o` cycles per frame, `frame_start_o` period = 1237500.
- Async reset mid-line at x=100, y=300 → outputs go to the reset state with no clock edge. After release, timing restarts at (0,0).

Source files
------------

// File: rtl/sync_generator_if.sv
// Raster timing bundle between the sync generator and the overlay/pixel
// pipeline. The generator owns the timing outputs; the consumer owns the
// run enable.
interface sync_generator_if;
  logic        en;
  logic        hsync_o;
  logic        vsync_o;
  logic        de_o;
  logic [11:0] x_o;
  logic [11:0] y_o;
  logic        frame_start_o;

  modport master (
    input  en,
    output hsync_o, vsync_o, de_o, x_o, y_o, frame_start_o
  );

  modport slave (
    output en,
    input  hsync_o, vsync_o, de_o, x_o, y_o, frame_start_o
  );
endinterface

// File: rtl/sync_generator.sv
// Programmable raster timing generator for the HDMI output path.
// A horizontal/vertical counter pair walks the raster in the order
// active -> front porch -> sync -> back porch. The decode of the counters
// is registered once, so every output (including x/y) lags the counters
// by exactly one pixel clock. Syncs are decoded active-high internally and
// converted to the sink's polarity at the output register.
module sync_generator #(
  parameter int H_ACTIVE  = 1280,
  parameter int H_FP      = 110,
  parameter int H_SYNC    = 40,
  parameter int H_BP      = 220,
  parameter int V_ACTIVE  = 720,
  parameter int V_FP      = 5,
  parameter int V_SYNC    = 5,
  parameter int V_BP      = 20,
  parameter int HSYNC_POL = 1,
  parameter int VSYNC_POL = 1
) (
  input  logic              pxlClk,
  input  logic              rst,
  sync_generator_if.master  sg
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

  // Decode thresholds are 13 bits wide: a sync end can equal 4096 when the
  // back porch is zero and the total is the full 12-bit range.
  localparam logic [12:0] H_DE_END = 13'(H_ACTIVE);
  localparam logic [12:0] H_HS_BEG = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] H_HS_END = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] V_DE_END = 13'(V_ACTIVE);
  localparam logic [12:0] V_VS_BEG = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] V_VS_END = 13'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_LVL = (HSYNC_POL != 0);
  localparam logic VS_LVL = (VSYNC_POL != 0);

  // Map an internal active-high sync onto the pin level the sink expects.
  function automatic logic drive_level(input logic asserted, input logic level);
    return asserted ? level : ~level;
  endfunction

  logic [11:0] hcnt_p0;
  logic [11:0] vcnt_p0;
  logic        de_p0;
  logic        hs_p0;
  logic        vs_p0;
  logic        fs_p0;

  logic        hsync_p1;
  logic        vsync_p1;
  logic        de_p1;
  logic [11:0] x_p1;
  logic [11:0] y_p1;
  logic        fs_p1;

  // ---- stage p0: raster counters ----
  // Walk the raster while enabled; any idle cycle parks both counters at the
  // origin so a re-enable always starts a fresh frame.
  always_ff @(posedge pxlClk or negedge rst) begin
    if (!rst) begin
      hcnt_p0 <= '0;
      vcnt_p0 <= '0;
    end else if (!sg.en) begin
      hcnt_p0 <= '0;
      vcnt_p0 <= '0;
    end else if (hcnt_p0 == H_LAST) begin
      hcnt_p0 <= '0;
      vcnt_p0 <= (vcnt_p0 == V_LAST) ? 12'd0 : vcnt_p0 + 12'd1;
    end else begin
      hcnt_p0 <= hcnt_p0 + 12'd1;
    end
  end

  // Decode active video, syncs and frame origin from the current counters.
  always_comb begin
    de_p0 = 1'b0;
    hs_p0 = 1'b0;
    vs_p0 = 1'b0;
    fs_p0 = 1'b0;
    de_p0 = ({1'b0, hcnt_p0} < H_DE_END) && ({1'b0, vcnt_p0} < V_DE_END);
    hs_p0 = ({1'b0, hcnt_p0} >= H_HS_BEG) && ({1'b0, hcnt_p0} < H_HS_END);
    vs_p0 = ({1'b0, vcnt_p0} >= V_VS_BEG) && ({1'b0, vcnt_p0} < V_VS_END);
    fs_p0 = (hcnt_p0 == 12'd0) && (vcnt_p0 == 12'd0);
  end

  // ---- stage p1: registered outputs ----
  // Register the decode together with the coordinates so x/y stay aligned to
  // de; idle cycles present the same levels as reset.
  always_ff @(posedge pxlClk or negedge rst) begin
    if (!rst) begin
      hsync_p1 <= ~HS_LVL;
      vsync_p1 <= ~VS_LVL;
      de_p1    <= 1'b0;
      x_p1     <= '0;
      y_p1     <= '0;
      fs_p1    <= 1'b0;
    end else if (!sg.en) begin
      hsync_p1 <= ~HS_LVL;
      vsync_p1 <= ~VS_LVL;
      de_p1    <= 1'b0;
      x_p1     <= '0;
      y_p1     <= '0;
      fs_p1    <= 1'b0;
    end else begin
      hsync_p1 <= drive_level(hs_p0, HS_LVL);
      vsync_p1 <= drive_level(vs_p0, VS_LVL);
      de_p1    <= de_p0;
      x_p1     <= hcnt_p0;
      y_p1     <= vcnt_p0;
      fs_p1    <= fs_p0;
    end
  end

  assign sg.hsync_o       = hsync_p1;
  assign sg.vsync_o       = vsync_p1;
  assign sg.de_o          = de_p1;
  assign sg.x_o           = x_p1;
  assign sg.y_o           = y_p1;
  assign sg.frame_start_o = fs_p1;

endmodule

// File: tb/tb_sync_generator.sv
// Bench for sync_generator on a small 14x7 raster. Two instances share
// clock, reset and enable: one with active-high syncs, one with active-low.
// The driver pushes the expected output of each clock edge, computed from a
// linear pixel index into the frame, into a queue; the monitor pops one
// entry per edge and compares both instances against it.
module tb_sync_generator;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;   // 14
  localparam int VT = VA + VF + VS + VB;   // 7
  localparam int FRAME = HT * VT;          // 98

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [11:0] x;
    logic [11:0] y;
  } exp_t;

  logic pxlClk = 1'b0;
  logic rst;
  logic en_drv;

  always #5 pxlClk = ~pxlClk;

  sync_generator_if ifa ();
  sync_generator_if ifb ();

  assign ifa.en = en_drv;
  assign ifb.en = en_drv;

  sync_generator #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1), .VSYNC_POL(1)
  ) dut_a (
    .pxlClk(pxlClk),
    .rst   (rst),
    .sg    (ifa.master)
  );

  sync_generator #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(0), .VSYNC_POL(0)
  ) dut_b (
    .pxlClk(pxlClk),
    .rst   (rst),
    .sg    (ifb.master)
  );

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   pos   = 0;   // index of the next pixel in the frame, row-major

  // Expected outputs for a given pixel index, straight from the raster rules.
  function automatic exp_t model_at(input int p);
    exp_t e;
    int x, y;
    x = p % HT;
    y = p / HT;
    e.x  = 12'(x);
    e.y  = 12'(y);
    e.de = (x < HA) && (y < VA);
    e.hs = (x >= HA + HF) && (x < HA + HF + HS);
    e.vs = (y >= VA + VF) && (y < VA + VF + VS);
    e.fs = (p == 0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  task automatic check_all(input exp_t e, input string tag);
    logic hs_lo, vs_lo;
    hs_lo = ~e.hs;
    vs_lo = ~e.vs;
    chk({tag, ".a.hsync"}, {11'd0, ifa.hsync_o},       {11'd0, e.hs});
    chk({tag, ".a.vsync"}, {11'd0, ifa.vsync_o},       {11'd0, e.vs});
    chk({tag, ".a.de"},    {11'd0, ifa.de_o},          {11'd0, e.de});
    chk({tag, ".a.fs"},    {11'd0, ifa.frame_start_o}, {11'd0, e.fs});
    chk({tag, ".a.x"},     ifa.x_o,                    e.x);
    chk({tag, ".a.y"},     ifa.y_o,                    e.y);
    chk({tag, ".b.hsync"}, {11'd0, ifb.hsync_o},       {11'd0, hs_lo});
    chk({tag, ".b.vsync"}, {11'd0, ifb.vsync_o},       {11'd0, vs_lo});
    chk({tag, ".b.de"},    {11'd0, ifb.de_o},          {11'd0, e.de});
    chk({tag, ".b.fs"},    {11'd0, ifb.frame_start_o}, {11'd0, e.fs});
    chk({tag, ".b.x"},     ifb.x_o,                    e.x);
    chk({tag, ".b.y"},     ifb.y_o,                    e.y);
  endtask

  // One clock of stimulus: set inputs for the coming edge and record what
  // that edge must produce.
  task automatic step(input logic rst_v, input logic en_v);
    @(negedge pxlClk);
    rst    = rst_v;
    en_drv = en_v;
    if (rst_v && en_v) begin
      q.push_back(model_at(pos));
      pos = (pos + 1) % FRAME;
    end else begin
      q.push_back('0);
      pos = 0;
    end
  endtask

  // Monitor: every edge presents one output sample to compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge pxlClk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check_all(e, "edge");
      end
    end
  end

  initial begin
    rst    = 1'b1;
    en_drv = 1'b1;
    #1 rst = 1'b0;

    // Held in reset with enable high.
    repeat (3) step(1'b0, 1'b1);

    // Free-running over two full frames and a bit.
    repeat (2 * FRAME + 20) step(1'b1, 1'b1);

    // Enable drop at x=5, y=2, idle for 20 cycles, then restart.
    while (pos != 2 * HT + 5) step(1'b1, 1'b1);
    repeat (20) step(1'b1, 1'b0);
    repeat (120) step(1'b1, 1'b1);

    // Randomised enable with occasional drops.
    for (int i = 0; i < 1200; i++) begin
      step(1'b1, ($urandom_range(0, 149) != 0));
    end

    // Asynchronous reset between edges while showing x=5, y=3.
    while (pos != 3 * HT + 5) step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    @(posedge pxlClk);
    #2 rst = 1'b0;
    #1 check_all('0, "async_rst");
    repeat (4) step(1'b0, 1'b1);
    repeat (150) step(1'b1, 1'b1);

    repeat (3) @(posedge pxlClk);
    #2;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain actual=%0d required=0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
